// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: IF FSM states, NOP word and base opcodes.
package if_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } if_state_e;

   // ADDI x0,x0,0 -- the canonical RV32I no-op
   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   // Sequential fetch address; wraps modulo 2^32
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry hold buffer for a fetched word that decode could not accept.
module if_skid_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [31:0] instr_d,
   input  logic [31:0] pc_d,
   output logic [31:0] instr_q,
   output logic [31:0] pc_q,
   output logic        vld_q
);

   // Occupancy flag: set on capture, dropped on drain or redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        vld_q <= 1'b0;
      else if (clear) vld_q <= 1'b0;
      else if (load)  vld_q <= 1'b1;
   end

   // Payload is qualified by vld_q, so it needs no reset
   always_ff @(posedge clk) begin
      if (load) begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding the IF/ID register.
// Optional feature: define IF_MISALIGN_TRAP_EN to add misalign_o and block fetch
// after a misaligned redirect; otherwise redirect targets are forced word-aligned.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [6:0]  opcode_o,
   output logic [2:0]  func3_o
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic        misalign_o
`endif
);

   if_state_e   state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] redirect_tgt;
   logic        kill_q, kill_d;
   logic        trap_q;
   logic        granted;
   logic        ifid_load, ifid_clear;
   logic [31:0] ifid_instr, ifid_pc;
   logic        skid_load, skid_clear, skid_vld;
   logic [31:0] skid_instr, skid_pc;
   logic        vld_p0;
   logic [31:0] instr_p0, pc_p0;

`ifdef IF_MISALIGN_TRAP_EN
   assign redirect_tgt = redirect_pc_i;
   assign misalign_o   = trap_q;

   // Trap latch: any redirect re-evaluates alignment of its target
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)           trap_q <= 1'b0;
      else if (redirect_i) trap_q <= |redirect_pc_i[1:0];
   end
`else
   assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
   assign trap_q       = 1'b0;
`endif

   assign imem_req_o  = (state_q == REQ) && !trap_q;
   assign imem_addr_o = fetch_pc_q;
   assign granted     = imem_req_o && imem_gnt_i;

   if_skid_buf u_skid (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (skid_load),
      .clear   (skid_clear),
      .instr_d (imem_rdata_i),
      .pc_d    (fetch_pc_q),
      .instr_q (skid_instr),
      .pc_q    (skid_pc),
      .vld_q   (skid_vld)
   );

   // Next-state, fetch address, kill flag and IF/ID / buffer controls
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      kill_d     = kill_q;
      ifid_load  = 1'b0;
      ifid_clear = !stall_i;   // decode consumed the current word
      ifid_instr = imem_rdata_i;
      ifid_pc    = fetch_pc_q;
      skid_load  = 1'b0;
      skid_clear = 1'b0;

      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (granted) state_d = WAIT;
         WAIT: begin
            if (imem_rvalid_i) begin
               if (kill_q) begin
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else if (stall_i) begin
                  skid_load = 1'b1;
                  state_d   = HOLD;
               end else begin
                  ifid_load  = 1'b1;
                  fetch_pc_d = pc_next(fetch_pc_q);
                  state_d    = REQ;
               end
            end
         end
         HOLD: begin
            if (!stall_i) begin
               ifid_load  = skid_vld;
               ifid_instr = skid_instr;
               ifid_pc    = skid_pc;
               skid_clear = 1'b1;
               fetch_pc_d = pc_next(fetch_pc_q);
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      // Redirect overrides stall and any word in flight
      if (redirect_i) begin
         fetch_pc_d = redirect_tgt;
         ifid_load  = 1'b0;
         ifid_clear = 1'b1;
         skid_load  = 1'b0;
         skid_clear = 1'b1;
         if ((state_q == WAIT && !imem_rvalid_i) || (state_q == REQ && granted)) begin
            // A response is still owed for the old address: wait it out and drop it
            kill_d  = 1'b1;
            state_d = WAIT;
         end else begin
            kill_d  = 1'b0;
            state_d = REQ;
         end
      end
   end

   // FSM, fetch address and kill flag registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         kill_q     <= kill_d;
      end
   end

   // IF/ID boundary: load a new word, drop a consumed one, or hold under stall
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_p0   <= 1'b0;
         instr_p0 <= NOP_INSTR;
         pc_p0    <= 32'h0000_0000;
      end else if (ifid_load) begin
         vld_p0   <= 1'b1;
         instr_p0 <= ifid_instr;
         pc_p0    <= ifid_pc;
      end else if (ifid_clear) begin
         vld_p0   <= 1'b0;
      end
   end

   assign valid_o  = vld_p0;
   assign instr_o  = vld_p0 ? instr_p0 : NOP_INSTR;
   assign pc_o     = pc_p0;
   assign opcode_o = instr_o[6:0];
   assign func3_o  = instr_o[14:12];

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage (default build, trap feature off).
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        valid;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [6:0]  opcode;
   logic [2:0]  func3;

   int checks = 0;
   int fails  = 0;

   if_stage dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (imem_req),
      .imem_addr_o   (imem_addr),
      .imem_gnt_i    (imem_gnt),
      .imem_rvalid_i (imem_rvalid),
      .imem_rdata_i  (imem_rdata),
      .valid_o       (valid),
      .instr_o       (instr),
      .pc_o          (pc),
      .opcode_o      (opcode),
      .func3_o       (func3)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One granted request followed by a same-cycle response
   task automatic fetch_word(input logic [31:0] w);
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = w;
      step();
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL rst_valid: got %b want 0", valid); end
      checks++; if (instr !== 32'h13)       begin fails++; $display("FAIL rst_instr: got %h want 00000013", instr); end
      checks++; if (pc !== 32'h0)           begin fails++; $display("FAIL rst_pc: got %h want 0", pc); end
      checks++; if (imem_req !== 1'b0)      begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
      checks++; if (imem_addr !== 32'h0)    begin fails++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0)      begin fails++; $display("FAIL idle_req: got %b want 0", imem_req); end
      step();
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL first_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h0)    begin fails++; $display("FAIL first_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_basic_fetch();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      checks++; if (imem_req !== 1'b0)      begin fails++; $display("FAIL wait_req: got %b want 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0000_0537;
      step();
      imem_rvalid = 1'b0;
      checks++; if (valid !== 1'b1)         begin fails++; $display("FAIL basic_valid: got %b want 1", valid); end
      checks++; if (instr !== 32'h537)      begin fails++; $display("FAIL basic_instr: got %h want 00000537", instr); end
      checks++; if (opcode !== 7'b0110111)  begin fails++; $display("FAIL basic_opcode: got %b want 0110111", opcode); end
      checks++; if (pc !== 32'h0)           begin fails++; $display("FAIL basic_pc: got %h want 0", pc); end
      checks++; if (imem_addr !== 32'h4)    begin fails++; $display("FAIL basic_next_addr: got %h want 4", imem_addr); end
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL basic_next_req: got %b want 1", imem_req); end
   endtask

   task automatic test_stall();
      fetch_word(32'h0010_0093);
      checks++; if (pc !== 32'h4)           begin fails++; $display("FAIL pre_stall_pc: got %h want 4", pc); end
      stall    = 1'b1;
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h00A0_0093;
      step();
      imem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (instr !== 32'h0010_0093) begin fails++; $display("FAIL stall_instr[%0d]: got %h want 00100093", i, instr); end
         checks++; if (pc !== 32'h4)            begin fails++; $display("FAIL stall_pc[%0d]: got %h want 4", i, pc); end
         checks++; if (imem_req !== 1'b0)       begin fails++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
         if (i < 2) step();
      end
      stall = 1'b0;
      step();
      checks++; if (valid !== 1'b1)         begin fails++; $display("FAIL unstall_valid: got %b want 1", valid); end
      checks++; if (instr !== 32'h00A0_0093) begin fails++; $display("FAIL unstall_instr: got %h want 00a00093", instr); end
      checks++; if (pc !== 32'h8)           begin fails++; $display("FAIL unstall_pc: got %h want 8", pc); end
      checks++; if (imem_addr !== 32'hC)    begin fails++; $display("FAIL unstall_addr: got %h want c", imem_addr); end
      step();
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL no_dup_valid: got %b want 0", valid); end
   endtask

   task automatic test_redirect_wait();
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b0)      begin fails++; $display("FAIL kill_req: got %b want 0", imem_req); end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      step();
      imem_rvalid = 1'b0;
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL stale_valid: got %b want 0", valid); end
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL redir_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h100)  begin fails++; $display("FAIL redir_addr: got %h want 100", imem_addr); end
      fetch_word(32'h0020_9133);
      checks++; if (pc !== 32'h100)         begin fails++; $display("FAIL redir_pc: got %h want 100", pc); end
      checks++; if (instr !== 32'h0020_9133) begin fails++; $display("FAIL redir_instr: got %h want 00209133", instr); end
      checks++; if (func3 !== 3'b001)       begin fails++; $display("FAIL redir_func3: got %b want 001", func3); end
      checks++; if (opcode !== 7'b0110011)  begin fails++; $display("FAIL redir_opcode: got %b want 0110011", opcode); end
   endtask

   task automatic test_redirect_stall();
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      stall    = 1'b0;
      redirect = 1'b0;
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL rs_valid: got %b want 0", valid); end
      checks++; if (imem_addr !== 32'h200)  begin fails++; $display("FAIL rs_addr: got %h want 200", imem_addr); end
      fetch_word(32'h0040_006F);
      checks++; if (pc !== 32'h200)         begin fails++; $display("FAIL rs_pc: got %h want 200", pc); end
      checks++; if (opcode !== 7'b1101111)  begin fails++; $display("FAIL rs_opcode: got %b want 1101111", opcode); end
   endtask

   task automatic test_redirect_req();
      redirect    = 1'b1;
      redirect_pc = 32'h302;
      step();
      redirect = 1'b0;
      checks++; if (imem_addr !== 32'h300)  begin fails++; $display("FAIL req_redir_addr: got %h want 300", imem_addr); end
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL req_redir_req: got %b want 1", imem_req); end
   endtask

   task automatic test_coincide();
      imem_gnt = 1'b1;
      step();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0013;
      redirect    = 1'b1;
      redirect_pc = 32'h500;
      step();
      imem_rvalid = 1'b0;
      redirect    = 1'b0;
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL coin_valid: got %b want 0", valid); end
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL coin_req: got %b want 1", imem_req); end
      checks++; if (imem_addr !== 32'h500)  begin fails++; $display("FAIL coin_addr: got %h want 500", imem_addr); end
      fetch_word(32'h0000_0537);
      checks++; if (pc !== 32'h500)         begin fails++; $display("FAIL coin_pc: got %h want 500", pc); end
   endtask

   task automatic test_wrap();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      fetch_word(32'h00A0_0093);
      checks++; if (pc !== 32'hFFFF_FFFC)   begin fails++; $display("FAIL wrap_pc: got %h want fffffffc", pc); end
      checks++; if (imem_addr !== 32'h0)    begin fails++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
   endtask

   task automatic test_reset_mid();
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL mid_rst_valid: got %b want 0", valid); end
      checks++; if (instr !== 32'h13)       begin fails++; $display("FAIL mid_rst_instr: got %h want 00000013", instr); end
      checks++; if (pc !== 32'h0)           begin fails++; $display("FAIL mid_rst_pc: got %h want 0", pc); end
      step();
      rst         = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBADC_0DE3;
      step();
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL late_valid0: got %b want 0", valid); end
      checks++; if (imem_req !== 1'b1)      begin fails++; $display("FAIL late_req: got %b want 1", imem_req); end
      step();
      imem_rvalid = 1'b0;
      checks++; if (valid !== 1'b0)         begin fails++; $display("FAIL late_valid1: got %b want 0", valid); end
      checks++; if (instr !== 32'h13)       begin fails++; $display("FAIL late_instr: got %h want 00000013", instr); end
      fetch_word(32'h0000_0537);
      checks++; if (instr !== 32'h537)      begin fails++; $display("FAIL recover_instr: got %h want 00000537", instr); end
      checks++; if (pc !== 32'h0)           begin fails++; $display("FAIL recover_pc: got %h want 0", pc); end
   endtask

   initial begin
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_wait();
      test_redirect_stall();
      test_redirect_req();
      test_coincide();
      test_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), driven on instr_o whenever valid_o is low.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk_i, input, 1, the single clock.
- rst_i, input, 1, reset; asynchronous and active-high.
- stall_i, input, 1, decode cannot accept; hold the IF/ID register.
- redirect_i, input, 1, taken branch or jump (decoder PC_control_o).
- redirect_pc_i, input, 32, target address for the redirect.
- imem_req_o, output, 1, fetch request.
- imem_addr_o, output, 32, fetch address.
- imem_gnt_i, input, 1, request accepted this cycle.
- imem_rvalid_i, input, 1, response data valid.
- imem_rdata_i, input, 32, response instruction word.
- valid_o, output, 1, IF/ID register holds a live instruction.
- instr_o, output, 32, IF/ID instruction.
- pc_o, output, 32, PC of instr_o.
- opcode_o, output, 7, instr_o[6:0], feeds the decoder opcode input.
- func3_o, output, 3, instr_o[14:12], feeds the decoder func3 input.

Function
REQ-004 The block SHALL implement FSM states IDLE, REQ, WAIT and HOLD.
REQ-005 IDLE SHALL last exactly one cycle after reset release, then go to REQ with fetch_pc = RESET_PC.
REQ-006 In REQ, imem_req_o SHALL be 1 and imem_addr_o SHALL equal fetch_pc; on imem_gnt_i the FSM SHALL go to WAIT; imem_addr_o SHALL be stable until granted.
REQ-007 At most one request SHALL be outstanding; imem_req_o SHALL be 0 in WAIT and HOLD.
REQ-008 In WAIT, on imem_rvalid_i with no kill pending and stall_i = 0:
- the IF/ID register SHALL load instr_o = imem_rdata_i, pc_o = fetch_pc, valid_o = 1 on the next edge;
- fetch_pc SHALL advance by 4 (wrapping modulo 2^32);
- the FSM SHALL return to REQ.
REQ-009 In the same case with stall_i = 1, the word SHALL be captured into a one-entry hold buffer and the FSM SHALL go to HOLD.
REQ-010 In HOLD, the IF/ID register and hold buffer SHALL be frozen while stall_i = 1. When stall_i falls, the buffer SHALL move into IF/ID on that edge, fetch_pc SHALL advance by 4, and the FSM SHALL go to REQ.
REQ-011 When stall_i = 1 and no new word is arriving, the IF/ID register SHALL hold its contents; instr_o, pc_o and valid_o SHALL stay unchanged.
REQ-012 redirect_i = 1 SHALL take priority over stall_i and SHALL, on the next edge:
- clear valid_o;
- discard the hold buffer;
- set fetch_pc = redirect_pc_i;
- move the FSM to REQ.
REQ-013 If redirect_i arrives in WAIT, a kill flag SHALL be set; the pending response SHALL be dropped and clear the flag; the FSM SHALL then issue a request to the new target.
REQ-014 redirect_i in REQ before grant SHALL replace imem_addr_o with the new target on the next cycle without waiting for a grant.
REQ-015 If redirect_i and imem_rvalid_i coincide, the arriving word SHALL be discarded.
REQ-016 Best-case throughput SHALL be one instruction per two cycles (REQ, then WAIT with same-cycle rvalid).
REQ-017 opcode_o and func3_o SHALL be purely combinational slices of instr_o.

Reset
REQ-018 While rst_i = 1 and on its release, the block SHALL hold: FSM = IDLE, fetch_pc = RESET_PC, valid_o = 0, instr_o = NOP_INSTR, pc_o = 0, imem_req_o = 0, imem_addr_o = RESET_PC, kill flag = 0, hold buffer empty.
REQ-019 Reset asserted mid-transaction SHALL abandon it; a late imem_rvalid_i after reset SHALL be ignored until the block has issued a new request.

Configuration
REQ-020 With IF_MISALIGN_TRAP_EN defined, the block SHALL:
- add output misalign_o (1 bit);
- on a redirect with redirect_pc_i[1:0] != 0, set misalign_o = 1 and issue no request until the next reset or aligned redirect.
REQ-021 Without IF_MISALIGN_TRAP_EN, misalign_o SHALL not exist and redirect_pc_i[1:0] SHALL be forced to 2'b00.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the NOP_INSTR constant and the opcode constants (LUI, JAL, BRANCH, LOAD, OP_IMM), which the decoder also uses.
REQ-023 The hold buffer SHALL be a sub-module if_skid_buf containing 1 entry (data + pc + valid).

Verification
REQ-024 Reset release, memory granting immediately, rdata = 32'h0000_0537 -> imem_addr_o 0x0, then 0x4; valid_o = 1; instr_o = 32'h0000_0537; opcode_o = 7'b0110111.
REQ-025 stall_i held 3 cycles as word 0x00A00093 arrives at pc 0x8 -> instr_o/pc_o frozen; after release, instr_o = 0x00A00093, pc_o = 0x8; no word lost or duplicated.
REQ-026 redirect_i with redirect_pc_i = 0x100 while in WAIT -> stale response dropped; next imem_addr_o = 0x100; next valid pc_o = 0x100.
REQ-027 redirect_i and stall_i both high -> valid_o = 0 next cycle; fetch resumes at the target.
REQ-028 fetch_pc = 0xFFFF_FFFC with a fetch completing -> next imem_addr_o = 0x0000_0000.
REQ-029 rst_i asserted in WAIT, then a late rvalid -> outputs at reset values; late word never appears on instr_o.
